// File: rtl/matmul_pkg.sv
// matmul_pkg: shared states, widths and element helpers for the 2x2 matrix multiplier sequencer
package matmul_pkg;
  typedef enum logic [2:0] {LOAD_A, LOAD_B, COMPUTE, OUT0, OUT1} state_t;
  localparam int ELEM_W = 2;
  localparam int ACC_W = 4;
  localparam logic [ELEM_W-1:0] ELEM_MAX = 2'd2;
  localparam logic [1:0] X11 = 2'd0;
  localparam logic [1:0] X12 = 2'd1;
  localparam logic [1:0] X21 = 2'd2;
  localparam logic [1:0] X22 = 2'd3;
  function automatic logic [ELEM_W-1:0] elem(input logic [7:0] x, input logic [1:0] idx);
    return x[idx*ELEM_W +: ELEM_W];
  endfunction
  function automatic logic has_err(input logic [7:0] x);
    logic e;
    e = 1'b0;
    for (int i = 0; i < 4; i++) e = e | (elem(x, 2'(i)) > ELEM_MAX);
    return e;
  endfunction
endpackage

// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: input byte stream (in_valid/in_ready/in_data) and output byte stream (out_valid/out_ready/out_data)
interface matmul_sequencer_if;
  logic in_valid;
  logic in_ready;
  logic [7:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [7:0] out_data;
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
endinterface

// File: rtl/matmul_mac.sv
// matmul_mac: 2b x 2b multiply-accumulate; ports clk, rst_n, en, clr (restart sum), a, b, acc_nxt (value the accumulator takes this step)
module matmul_mac
  import matmul_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ACC_W-1:0] acc_nxt
);
  logic [ACC_W-1:0] acc;
  assign acc_nxt = (clr ? '0 : acc) + ACC_W'(a) * ACC_W'(b);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (en) acc <= acc_nxt;
endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: byte-serial C=A*B over one shared MAC; ports clk, rst_n, ena, io (A/B bytes in, C bytes out), busy, error
module matmul_sequencer
  import matmul_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  matmul_sequencer_if.slave io,
  output logic busy,
  output logic error
);
  state_t st, st_nxt;
  logic [2:0] k;
  logic [7:0] a_r, b_r, out_q;
  logic [3:0][ACC_W-1:0] c;
  logic [ACC_W-1:0] acc_nxt;
  logic in_xfer, out_xfer, run;
  assign io.in_ready = ena && (st == LOAD_A || st == LOAD_B);
  assign io.out_valid = ena && (st == OUT0 || st == OUT1);
  assign io.out_data = out_q;
  assign busy = st != LOAD_A;
  assign in_xfer = io.in_valid && io.in_ready;
  assign out_xfer = io.out_valid && io.out_ready;
  assign run = ena && st == COMPUTE;
  matmul_mac u_mac (
    .clk(clk),
    .rst_n(rst_n),
    .en(run),
    .clr(~k[0]),
    .a(elem(a_r, {k[2], k[0]})),
    .b(elem(b_r, {k[0], k[1]})),
    .acc_nxt(acc_nxt)
  );
  always_comb
    st_nxt = (st == LOAD_A && in_xfer) ? LOAD_B :
             (st == LOAD_B && in_xfer) ? COMPUTE :
             (run && k == 3'd7) ? OUT0 :
             (st == OUT0 && out_xfer) ? OUT1 :
             (st == OUT1 && out_xfer) ? LOAD_A : st;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= LOAD_A;
    else st <= st_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k <= '0;
      a_r <= '0;
      b_r <= '0;
      c <= '0;
      out_q <= '0;
      error <= 1'b0;
    end else begin
      if (in_xfer && st == LOAD_A) a_r <= io.in_data;
      if (in_xfer && st == LOAD_B) begin
        b_r <= io.in_data;
        error <= has_err(a_r) | has_err(io.in_data);
      end
      if (run) begin
        k <= k + 3'd1;
        if (k[0]) c[k[2:1]] <= error ? '0 : acc_nxt;
        if (k == 3'd7) out_q <= {c[X12], c[X11]};
      end
      if (out_xfer) out_q <= st == OUT0 ? {c[X22], c[X21]} : 8'h00;
      if (out_xfer && st == OUT1) error <= 1'b0;
    end
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: scoreboard bench with directed and random jobs against a matrix-level reference model
module tb_matmul_sequencer;
  logic clk, rst_n, ena, busy, error;
  matmul_sequencer_if io ();
  matmul_sequencer dut (.clk(clk), .rst_n(rst_n), .ena(ena), .io(io), .busy(busy), .error(error));
  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic err;
    int bcyc;
    int lat;
  } exp_t;
  exp_t sb[$];
  int cmps = 0, fails = 0, cyc = 0;
  bit bp_hold = 0;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmps++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] o0, output logic [7:0] o1, output logic e);
    int am[2][2], bm[2][2], cm[2][2];
    e = 0;
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < 2; q++) begin
        am[r][q] = (int'(a) >> (4 * r + 2 * q)) & 3;
        bm[r][q] = (int'(b) >> (4 * r + 2 * q)) & 3;
        if (am[r][q] == 3 || bm[r][q] == 3) e = 1;
      end
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < 2; q++)
        cm[r][q] = e ? 0 : am[r][0] * bm[0][q] + am[r][1] * bm[1][q];
    o0 = 8'(cm[0][1] * 16 + cm[0][0]);
    o1 = 8'(cm[1][1] * 16 + cm[1][0]);
  endfunction
  task automatic send(input logic [7:0] d);
    int n = 0;
    io.in_valid = 1;
    io.in_data = d;
    while (!io.in_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!io.in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    io.in_valid = 0;
    io.in_data = $urandom;
  endtask
  task automatic job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e0,
                     input logic [7:0] e1, input logic ee, input int extra);
    exp_t x;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    send(a);
    send(b);
    chk("error_at_b", error, ee);
    x.b0 = e0;
    x.b1 = e1;
    x.err = ee;
    x.bcyc = cyc;
    x.lat = 8 + extra;
    sb.push_back(x);
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!bp_hold) io.out_ready = $urandom_range(0, 3) != 0;
    end
  end
  int idx = 0;
  bit seen = 0, clr_chk = 0, held = 0;
  logic [7:0] last;
  always @(negedge clk) begin
    if (!rst_n) begin
      idx = 0;
      seen = 0;
      clr_chk = 0;
      held = 0;
    end else begin
      if (clr_chk) begin
        chk("error_cleared", error, 0);
        chk("out_data_cleared", io.out_data, 0);
        clr_chk = 0;
      end
      if (held) begin
        chk("hold_valid", io.out_valid, 1);
        chk("hold_data", io.out_data, last);
      end
      held = 0;
      if (io.out_valid) begin
        if (sb.size() == 0) chk("unexpected_out", io.out_valid, 0);
        else begin
          if (!seen) chk("latency", cyc - sb[0].bcyc, sb[0].lat);
          seen = 1;
          chk("error_held", error, sb[0].err);
          if (io.out_ready) begin
            chk(idx == 0 ? "out_byte0" : "out_byte1", io.out_data, idx == 0 ? sb[0].b0 : sb[0].b1);
            if (idx == 1) begin
              void'(sb.pop_front());
              idx = 0;
              seen = 0;
              clr_chk = 1;
            end else idx = 1;
          end else begin
            held = 1;
            last = io.out_data;
          end
        end
      end
    end
  end
  initial begin
    logic [7:0] a, b, o0, o1;
    logic e;
    int n;
    rst_n = 0;
    ena = 1;
    io.in_valid = 0;
    io.in_data = 0;
    io.out_ready = 1;
    #1;
    chk("rst_out_data", io.out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_error", error, 0);
    chk("rst_in_ready", io.in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    job(8'h49, 8'h16, 8'h14, 8'h01, 0, 0);
    job(8'h41, 8'hAA, 8'h22, 8'h22, 0, 0);
    job(8'hAA, 8'hAA, 8'h88, 8'h88, 0, 0);
    job(8'h03, 8'h16, 8'h00, 8'h00, 1, 0);
    drain();
    bp_hold = 1;
    io.out_ready = 0;
    job(8'h49, 8'h16, 8'h14, 8'h01, 0, 0);
    n = 0;
    while (!io.out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_reach_out0", io.out_valid, 1);
    repeat (5) @(posedge clk);
    #1;
    io.out_ready = 1;
    bp_hold = 0;
    job(8'h49, 8'h16, 8'h14, 8'h01, 0, 3);
    repeat (4) @(posedge clk);
    #1;
    ena = 0;
    chk("ena_low_in_ready", io.in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    ena = 1;
    drain();
    job(8'h41, 8'hAA, 8'h22, 8'h22, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0;
    void'(sb.pop_back());
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_data", io.out_data, 0);
    chk("midrst_in_ready", io.in_ready, 1);
    chk("midrst_error", error, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    job(8'h41, 8'hAA, 8'h22, 8'h22, 0, 0);
    for (int j = 0; j < 25; j++) begin
      a = 0;
      b = 0;
      for (int q = 0; q < 4; q++) begin
        a[2*q +: 2] = 2'($urandom_range(0, 2));
        b[2*q +: 2] = 2'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 5) == 0) a[2*$urandom_range(0, 3) +: 2] = 2'd3;
      if ($urandom_range(0, 5) == 0) b[2*$urandom_range(0, 3) +: 2] = 2'd3;
      model(a, b, o0, o1, e);
      job(a, b, o0, o1, e, 0);
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end
endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Byte-serial controller for the 2x2 unsigned matrix multiplier. It accepts matrix A then matrix B as packed bytes over a valid/ready input stream, and computes C = A·B by time-sharing one 2-bit×2-bit multiply-accumulate unit over 8 cycles. It returns C as two packed bytes over a valid/ready output stream. It sits between the chip pin interface and the arithmetic, replacing one-shot parallel evaluation with a sequenced, backpressure-aware flow.

## Interface
- No parameters. Fixed constants live in the package.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: global enable. When low, all state freezes and handshakes are suppressed.
- `in_valid` in 1: `in_data` holds a matrix byte.
- `in_ready` out 1: `ena` && state ∈ {LOAD_A, LOAD_B}.
- `in_data` in 8: packed matrix, element mapping:
  - x11 = [1:0], x12 = [3:2], x21 = [5:4], x22 = [7:6].
- `out_valid` out 1: `ena` && state ∈ {OUT0, OUT1}.
- `out_ready` in 1: consumer accepts `out_data`.
- `out_data` out 8, registered:
  - OUT0: {c12, c11}.
  - OUT1: {c22, c21}.
- `busy` out 1: state ∉ {LOAD_A}.
- `error` out 1: range error for the current job. Held from B acceptance until OUT1 is accepted.

## Operation
- Handshake: a transfer occurs on an edge where valid && ready && `ena`.
- FSM states: LOAD_A → LOAD_B → COMPUTE → OUT0 → OUT1 → LOAD_A.
  - LOAD_A / LOAD_B: capture `in_data` into the A or B register on transfer, then advance.
  - COMPUTE: 3-bit counter `k` runs 0..7.
    - Element index: (i,j) = `k[2:1]`, with 0=c11, 1=c12, 2=c21, 3=c22.
    - Term index: `k[0]`. Term 0 = a(i,1)·b(1,j); term 1 = a(i,2)·b(2,j).
    - Term 0 loads the accumulator; term 1 adds and writes the 4-bit result slot.
    - At k=7 the FSM moves to OUT0 and `out_data` is loaded with {c12, c11}.
  - OUT0: on transfer, `out_data` ← {c22, c21}, go to OUT1.
  - OUT1: on transfer, `out_data` ← 0, `error` ← 0, go to LOAD_A.
- Range check:
  - Valid elements are 0..2. Any element of A or B equal to 3 sets `error` at the B-acceptance edge.
  - An erroring job still runs all 8 COMPUTE cycles, but every result slot is written 0. Latency is identical to a valid job.
- Arithmetic:
  - Each product is at most 4 and the sum at most 8, so a 4-bit accumulator suffices.
  - No saturation logic.
- `ena` low: FSM, counter, A/B/C registers and `out_data` all hold. `in_ready` = `out_valid` = 0.

## Timing
- Reset values: state=LOAD_A, `k`=0, A=B=C=0, `out_data`=0x00, `error`=0.
  - With `ena`=1, `in_ready`=1 immediately after reset.
  - `busy`=0, `out_valid`=0.
- Throughput: at most one input byte per cycle; no bubble between the A and B bytes.
- Latency: the B transfer at edge N gives `out_valid`=1 after edge N+8 (8 COMPUTE cycles).
- Output backpressure: while `out_ready`=0 in OUT0 or OUT1, `out_data` and `out_valid` are held stable.
- `in_ready`=0 during COMPUTE/OUT0/OUT1. `in_valid` is ignored there; no data is lost or queued.
- `ena` deasserted mid-COMPUTE: `k` holds, and the count resumes exactly where it stopped.
- Reset mid-operation: asynchronous return to the reset values. The partial job is discarded.
- OUT1 transfer and a new A byte on the same edge: A is not accepted, because `in_ready` was 0. A is accepted from the following cycle.

## Structure
- Package `matmul_pkg` holds:
  - state enum (LOAD_A, LOAD_B, COMPUTE, OUT0, OUT1);
  - `ELEM_W`=2, `ACC_W`=4, `ELEM_MAX`=2;
  - element bit-slice index constants.
- Sub-module `matmul_mac`: inputs a, b (2-bit) and `clr`; 4-bit accumulator output. Registered, with async reset.
- The top level contains the FSM, `k` counter, A/B registers, 4×4-bit C register and output mux.

## Test plan
- Basic job: A=0x49, B=0x16 → out bytes 0x14 then 0x01, `error`=0. First `out_valid` occurs 8 cycles after the B transfer.
- Identity: A=0x41, B=0xAA → 0x22, 0x22.
- Max values: A=0xAA, B=0xAA → 0x88, 0x88, with no overflow.
- Range error: A=0x03, B=0x16 → `error`=1 from B acceptance, outputs 0x00, 0x00, same latency. After the OUT1 transfer, `error`=0.
- Backpressure plus `ena`:
  - Basic job with `out_ready`=0 for 5 cycles in OUT0 → 0x14 held stable.
  - `ena`=0 for 3 cycles at k=4 → results unchanged, latency +3.
- Reset mid-COMPUTE (k=3), then an identity job → state LOAD_A and `out_data`=0x00 immediately after reset; the next job yields 0x22, 0x22.
